// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the seven-segment digit drivers from the ALU result register.

module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]   scr_q, scr_d, adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d, ovf_q, ovf_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d, ovfo_q, ovfo_d, done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (.dig_i(scr_q[4*g +: 4]), .dig_o(adj[4*g +: 4]));
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovfo_d  = ovfo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        sign_d  = (SIGNED != 0) && bin[WIDTH-1];
        mag_d   = sign_d ? -bin : bin;
        scr_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = CW'(WIDTH);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // A set MSB in the adjusted top digit means a carry past the last digit.
        {scr_d, mag_d} = {adj, mag_q} << 1;
        if (adj[BW-1]) ovf_d = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        // A negative input always has a nonzero magnitude, so sign alone decides neg.
        bcd_d   = scr_q;
        neg_d   = sign_q;
        ovfo_d  = ovf_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovfo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovfo_q  <= ovfo_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = !ready;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = ovfo_q;
endmodule
